// File: rtl/issue_scoreboard.sv
// issue_scoreboard: per-register pending-write counters with operand
// forwarding and stall generation for an in-order issue stage.
// Optional macro SB_BRANCH_HAZARD_EN: when defined, a branch stalls instead of
// taking any read operand from a forwarding source, so branches only see
// register-file data.
module issue_scoreboard #(
  parameter int NUM_FWD = 3,
  parameter int CNT_W   = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [4:0]             issue_rs,
  input  logic [4:0]             issue_rt,
  input  logic                   issue_rs_r,
  input  logic                   issue_rt_r,
  input  logic [4:0]             issue_waddr,
  input  logic                   issue_branch,
  input  logic [31:0]            rf_rdata1,
  input  logic [31:0]            rf_rdata2,
  input  logic [NUM_FWD*5-1:0]   fwd_addr,
  input  logic [NUM_FWD*32-1:0]  fwd_data,
  input  logic [NUM_FWD-1:0]     fwd_ok,
  input  logic                   retire_valid,
  input  logic [4:0]             retire_addr,
  input  logic                   flush,
  output logic [31:0]            rdata1_o,
  output logic [31:0]            rdata2_o,
  output logic                   busy_o,
  output logic                   err_o,
  output logic [31:0]            stall_cnt_o
);

`ifdef SB_BRANCH_HAZARD_EN
  localparam logic BR_HAZ = 1'b1;
`else
  localparam logic BR_HAZ = 1'b0;
`endif

  // Entry 0 exists only so the array can be indexed by a raw register number;
  // it is held at zero and never counts.
  logic [CNT_W-1:0] r_cnt [32];
  logic             r_err;
  logic [31:0]      r_stall_cnt;

  logic        w_stall1;
  logic        w_stall2;
  logic        w_ready_core;
  logic        w_fire;
  logic        w_underflow;
  logic        w_busy;

  // Resolve one source operand: returns {stall, data}. The youngest
  // forwarding stage with a matching address wins, even if its result is not
  // ready yet; register 0 is hard-wired to zero and never stalls.
  function automatic logic [32:0] resolve(input logic [4:0]       r,
                                          input logic             rd,
                                          input logic [31:0]      rf,
                                          input logic [CNT_W-1:0] cnt_r);
    logic        hit;
    logic        ok;
    logic [31:0] fdat;
    logic        stall;
    logic [31:0] data;
    hit  = 1'b0;
    ok   = 1'b0;
    fdat = '0;
    // Walk oldest to youngest so the lowest matching index is left standing.
    for (int f = NUM_FWD - 1; f >= 0; f--) begin
      if (fwd_addr[f*5 +: 5] == r) begin
        hit  = 1'b1;
        ok   = fwd_ok[f];
        fdat = fwd_data[f*32 +: 32];
      end
    end
    if (r == 5'd0) begin
      data  = '0;
      stall = 1'b0;
    end else if (hit) begin
      data  = fdat;
      stall = rd && (!ok || (BR_HAZ && issue_branch));
    end else begin
      data  = rf;
      stall = rd && (cnt_r != '0);
    end
    return {stall, data};
  endfunction

  assign {w_stall1, rdata1_o} = resolve(issue_rs, issue_rs_r, rf_rdata1, r_cnt[issue_rs]);
  assign {w_stall2, rdata2_o} = resolve(issue_rt, issue_rt_r, rf_rdata2, r_cnt[issue_rt]);

  // Internal readiness excludes reset so the counter flops never see resetn on
  // their data path; the port additionally forces ready low during reset.
  assign w_ready_core = issue_valid && !w_stall1 && !w_stall2 &&
                        (r_cnt[issue_waddr] != {CNT_W{1'b1}});
  assign issue_ready  = w_ready_core && resetn;
  assign w_fire       = issue_valid && w_ready_core;

  // A retire against an empty counter is an error unless a same-cycle issue
  // cancels it or a flush discards everything anyway.
  assign w_underflow = retire_valid && (retire_addr != 5'd0) &&
                       (r_cnt[retire_addr] == '0) &&
                       !(w_fire && (issue_waddr == retire_addr)) && !flush;

  // Busy when any tracked register still has a write in flight.
  always_comb begin
    w_busy = 1'b0;
    for (int i = 1; i < 32; i++) begin
      if (r_cnt[i] != '0) w_busy = 1'b1;
    end
  end

  // Pending-write counters: flush wins, issue+retire to one register cancel,
  // and a retire never takes a counter below zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) r_cnt[i] <= '0;
    end else begin
      r_cnt[0] <= '0;
      for (int i = 1; i < 32; i++) begin
        if (flush) begin
          r_cnt[i] <= '0;
        end else if (w_fire && (issue_waddr == 5'(i)) &&
                     !(retire_valid && (retire_addr == 5'(i)))) begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end else if (retire_valid && (retire_addr == 5'(i)) &&
                     !(w_fire && (issue_waddr == 5'(i))) && (r_cnt[i] != '0)) begin
          r_cnt[i] <= r_cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  // Sticky underflow flag and free-running stall counter; neither is flushed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err       <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      if (w_underflow) r_err <= 1'b1;
      if (issue_valid && !w_ready_core) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign busy_o      = w_busy;
  assign err_o       = r_err;
  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_issue_scoreboard.sv
module tb_issue_scoreboard;

  localparam int NUM_FWD = 3;
  localparam int CNT_W   = 2;

  logic                  clk;
  logic                  resetn;
  logic                  issue_valid;
  logic                  issue_ready;
  logic [4:0]            issue_rs;
  logic [4:0]            issue_rt;
  logic                  issue_rs_r;
  logic                  issue_rt_r;
  logic [4:0]            issue_waddr;
  logic                  issue_branch;
  logic [31:0]           rf_rdata1;
  logic [31:0]           rf_rdata2;
  logic [NUM_FWD*5-1:0]  fwd_addr;
  logic [NUM_FWD*32-1:0] fwd_data;
  logic [NUM_FWD-1:0]    fwd_ok;
  logic                  retire_valid;
  logic [4:0]            retire_addr;
  logic                  flush;
  logic [31:0]           rdata1_o;
  logic [31:0]           rdata2_o;
  logic                  busy_o;
  logic                  err_o;
  logic [31:0]           stall_cnt_o;

  typedef struct {
    logic        rdy;
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e;
  int          tests_run;
  int          tests_failed;
  logic [31:0] exp_stall;

  issue_scoreboard #(.NUM_FWD(NUM_FWD), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_rs     (issue_rs),
    .issue_rt     (issue_rt),
    .issue_rs_r   (issue_rs_r),
    .issue_rt_r   (issue_rt_r),
    .issue_waddr  (issue_waddr),
    .issue_branch (issue_branch),
    .rf_rdata1    (rf_rdata1),
    .rf_rdata2    (rf_rdata2),
    .fwd_addr     (fwd_addr),
    .fwd_data     (fwd_data),
    .fwd_ok       (fwd_ok),
    .retire_valid (retire_valid),
    .retire_addr  (retire_addr),
    .flush        (flush),
    .rdata1_o     (rdata1_o),
    .rdata2_o     (rdata2_o),
    .busy_o       (busy_o),
    .err_o        (err_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid  = 1'b0;
    issue_rs     = 5'd0;
    issue_rt     = 5'd0;
    issue_rs_r   = 1'b0;
    issue_rt_r   = 1'b0;
    issue_waddr  = 5'd0;
    issue_branch = 1'b0;
    rf_rdata1    = 32'd0;
    rf_rdata2    = 32'd0;
    fwd_addr     = '0;
    fwd_data     = '0;
    fwd_ok       = '0;
    retire_valid = 1'b0;
    retire_addr  = 5'd0;
    flush        = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle();
    issue_valid = 1'b1;
    #3;
    tests_run++;
    if (issue_ready !== 1'b0) begin
      tests_failed++; $display("FAIL reset_ready got %b want 0", issue_ready);
    end
    tick(); tick();
    tests_run++;
    if (busy_o !== 1'b0 || err_o !== 1'b0 || stall_cnt_o !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_state got busy=%b err=%b stall=%0d want 0/0/0", busy_o, err_o, stall_cnt_o);
    end
    idle();
    resetn = 1'b1;
    exp_stall = 32'd0;
  endtask

  task automatic test_forward();
    idle();
    issue_valid = 1'b1; issue_waddr = 5'd5;
    #1;
    tests_run++;
    if (issue_ready !== 1'b1) begin
      tests_failed++; $display("FAIL fwd_issue_w5 got %b want 1", issue_ready);
    end
    tick();
    tests_run++;
    if (busy_o !== 1'b1) begin
      tests_failed++; $display("FAIL fwd_busy got %b want 1", busy_o);
    end
    // forwarded from stage 0, rt from regfile
    issue_waddr = 5'd0;
    issue_rs = 5'd5; issue_rs_r = 1'b1; rf_rdata1 = 32'hdead;
    issue_rt = 5'd8; issue_rt_r = 1'b1; rf_rdata2 = 32'habcd;
    fwd_addr[4:0] = 5'd5; fwd_ok[0] = 1'b1; fwd_data[31:0] = 32'h1234;
    sb_q.push_back('{rdy: 1'b1, d1: 32'h1234, d2: 32'habcd});
    #1;
    e = sb_q.pop_front();
    tests_run++;
    if (issue_ready !== e.rdy || rdata1_o !== e.d1 || rdata2_o !== e.d2) begin
      tests_failed++;
      $display("FAIL fwd_hit got rdy=%b d1=%h d2=%h want rdy=%b d1=%h d2=%h",
               issue_ready, rdata1_o, rdata2_o, e.rdy, e.d1, e.d2);
    end
    tick();
    // no forwarding match, pending write -> stall
    fwd_addr = '0; fwd_ok = '0; fwd_data = '0;
    sb_q.push_back('{rdy: 1'b0, d1: 32'hdead, d2: 32'habcd});
    #1;
    e = sb_q.pop_front();
    tests_run++;
    if (issue_ready !== e.rdy || rdata1_o !== e.d1 || rdata2_o !== e.d2) begin
      tests_failed++;
      $display("FAIL fwd_pending got rdy=%b d1=%h d2=%h want rdy=%b d1=%h d2=%h",
               issue_ready, rdata1_o, rdata2_o, e.rdy, e.d1, e.d2);
    end
    tick();
    exp_stall++;
    tests_run++;
    if (stall_cnt_o !== exp_stall) begin
      tests_failed++; $display("FAIL fwd_stall_cnt got %0d want %0d", stall_cnt_o, exp_stall);
    end
    // register 0 resolves to zero even though fwd_addr==0 entries exist
    issue_rs = 5'd0; rf_rdata1 = 32'hffff;
    fwd_data = {32'h3333, 32'h2222, 32'h1111}; fwd_ok = '1;
    sb_q.push_back('{rdy: 1'b1, d1: 32'h0, d2: 32'habcd});
    #1;
    e = sb_q.pop_front();
    tests_run++;
    if (issue_ready !== e.rdy || rdata1_o !== e.d1 || rdata2_o !== e.d2) begin
      tests_failed++;
      $display("FAIL fwd_r0 got rdy=%b d1=%h d2=%h want rdy=%b d1=%h d2=%h",
               issue_ready, rdata1_o, rdata2_o, e.rdy, e.d1, e.d2);
    end
    tick();
    idle();
    retire_valid = 1'b1; retire_addr = 5'd5;
    tick();
    idle();
    tests_run++;
    if (busy_o !== 1'b0 || err_o !== 1'b0) begin
      tests_failed++; $display("FAIL fwd_retire got busy=%b err=%b want 0/0", busy_o, err_o);
    end
  endtask

  task automatic test_youngest();
    idle();
    issue_valid = 1'b1;
    issue_rs = 5'd7; issue_rs_r = 1'b1;
    fwd_addr = {5'd0, 5'd7, 5'd7};
    fwd_ok   = 3'b010;
    fwd_data = {32'h0, 32'h2222, 32'h1111};
    for (int c = 0; c < 3; c++) begin
      sb_q.push_back('{rdy: 1'b0, d1: 32'h1111, d2: 32'h0});
      #1;
      e = sb_q.pop_front();
      tests_run++;
      if (issue_ready !== e.rdy || rdata1_o !== e.d1 || rdata2_o !== e.d2) begin
        tests_failed++;
        $display("FAIL youngest_c%0d got rdy=%b d1=%h d2=%h want rdy=%b d1=%h d2=%h",
                 c, issue_ready, rdata1_o, rdata2_o, e.rdy, e.d1, e.d2);
      end
      tick();
      exp_stall++;
      tests_run++;
      if (stall_cnt_o !== exp_stall) begin
        tests_failed++; $display("FAIL youngest_stall_c%0d got %0d want %0d", c, stall_cnt_o, exp_stall);
      end
    end
    // source not read: no stall, data still follows the youngest match
    issue_rs_r = 1'b0;
    sb_q.push_back('{rdy: 1'b1, d1: 32'h1111, d2: 32'h0});
    #1;
    e = sb_q.pop_front();
    tests_run++;
    if (issue_ready !== e.rdy || rdata1_o !== e.d1 || rdata2_o !== e.d2) begin
      tests_failed++;
      $display("FAIL youngest_noread got rdy=%b d1=%h d2=%h want rdy=%b d1=%h d2=%h",
               issue_ready, rdata1_o, rdata2_o, e.rdy, e.d1, e.d2);
    end
    // a stalling operand with no valid instruction is not a stall cycle
    issue_rs_r = 1'b1; issue_valid = 1'b0;
    tick();
    tests_run++;
    if (stall_cnt_o !== exp_stall) begin
      tests_failed++; $display("FAIL youngest_novalid got %0d want %0d", stall_cnt_o, exp_stall);
    end
    idle();
  endtask

  task automatic test_saturate();
    idle();
    issue_valid = 1'b1; issue_waddr = 5'd3;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests_run++;
      if (issue_ready !== 1'b1) begin
        tests_failed++; $display("FAIL sat_issue%0d got %b want 1", k, issue_ready);
      end
      tick();
    end
    retire_valid = 1'b1; retire_addr = 5'd3;
    #1;
    tests_run++;
    if (issue_ready !== 1'b0) begin
      tests_failed++; $display("FAIL sat_full got %b want 0", issue_ready);
    end
    tick();
    exp_stall++;
    retire_valid = 1'b0;
    #1;
    tests_run++;
    if (issue_ready !== 1'b1) begin
      tests_failed++; $display("FAIL sat_after_retire got %b want 1", issue_ready);
    end
    tick();
    #1;
    tests_run++;
    if (issue_ready !== 1'b0) begin
      tests_failed++; $display("FAIL sat_back_to_3 got %b want 0", issue_ready);
    end
    tick();
    exp_stall++;
    tests_run++;
    if (stall_cnt_o !== exp_stall) begin
      tests_failed++; $display("FAIL sat_stall_cnt got %0d want %0d", stall_cnt_o, exp_stall);
    end
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tests_run++;
    if (busy_o !== 1'b0) begin
      tests_failed++; $display("FAIL sat_flush got busy=%b want 0", busy_o);
    end
  endtask

  task automatic test_same_cycle();
    idle();
    issue_valid = 1'b1; issue_waddr = 5'd2;
    tick();
    retire_valid = 1'b1; retire_addr = 5'd2;
    #1;
    tests_run++;
    if (issue_ready !== 1'b1) begin
      tests_failed++; $display("FAIL same_ready got %b want 1", issue_ready);
    end
    tick();
    idle();
    tests_run++;
    if (busy_o !== 1'b1) begin
      tests_failed++; $display("FAIL same_hold got busy=%b want 1", busy_o);
    end
    retire_valid = 1'b1; retire_addr = 5'd2;
    tick();
    idle();
    tests_run++;
    if (busy_o !== 1'b0 || err_o !== 1'b0) begin
      tests_failed++; $display("FAIL same_drain got busy=%b err=%b want 0/0", busy_o, err_o);
    end
  endtask

  task automatic test_error_flush();
    idle();
    retire_valid = 1'b1; retire_addr = 5'd9;
    tick();
    idle();
    tests_run++;
    if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      tests_failed++; $display("FAIL err_underflow got err=%b busy=%b want 1/0", err_o, busy_o);
    end
    issue_valid = 1'b1; issue_waddr = 5'd4; issue_rs = 5'd9; issue_rs_r = 1'b1;
    #1;
    tests_run++;
    if (issue_ready !== 1'b1) begin
      tests_failed++; $display("FAIL err_cnt9_zero got ready=%b want 1", issue_ready);
    end
    tick(); tick();
    idle();
    tests_run++;
    if (busy_o !== 1'b1) begin
      tests_failed++; $display("FAIL err_cnt4 got busy=%b want 1", busy_o);
    end
    flush = 1'b1; issue_valid = 1'b1; issue_waddr = 5'd4;
    tick();
    idle();
    tests_run++;
    if (busy_o !== 1'b0 || err_o !== 1'b1) begin
      tests_failed++; $display("FAIL err_flush got busy=%b err=%b want 0/1", busy_o, err_o);
    end
    issue_valid = 1'b1; issue_rs = 5'd4; issue_rs_r = 1'b1;
    #1;
    tests_run++;
    if (issue_ready !== 1'b1) begin
      tests_failed++; $display("FAIL err_flush_r4 got ready=%b want 1", issue_ready);
    end
    idle();
  endtask

  task automatic test_branch();
    idle();
    issue_valid = 1'b1; issue_branch = 1'b1;
    issue_rs = 5'd6; issue_rs_r = 1'b1; rf_rdata1 = 32'h9999;
    fwd_addr[4:0] = 5'd6; fwd_ok[0] = 1'b1; fwd_data[31:0] = 32'h5555;
`ifdef SB_BRANCH_HAZARD_EN
    sb_q.push_back('{rdy: 1'b0, d1: 32'h5555, d2: 32'h0});
`else
    sb_q.push_back('{rdy: 1'b1, d1: 32'h5555, d2: 32'h0});
`endif
    #1;
    e = sb_q.pop_front();
    tests_run++;
    if (issue_ready !== e.rdy || (e.rdy && rdata1_o !== e.d1)) begin
      tests_failed++;
      $display("FAIL branch_fwd got rdy=%b d1=%h want rdy=%b d1=%h", issue_ready, rdata1_o, e.rdy, e.d1);
    end
    fwd_addr = '0; fwd_ok = '0; fwd_data = '0;
    sb_q.push_back('{rdy: 1'b1, d1: 32'h9999, d2: 32'h0});
    #1;
    e = sb_q.pop_front();
    tests_run++;
    if (issue_ready !== e.rdy || rdata1_o !== e.d1) begin
      tests_failed++;
      $display("FAIL branch_rf got rdy=%b d1=%h want rdy=%b d1=%h", issue_ready, rdata1_o, e.rdy, e.d1);
    end
    idle();
  endtask

  task automatic test_async_reset();
    idle();
    issue_valid = 1'b1; issue_waddr = 5'd2;
    tick();
    idle();
    tests_run++;
    if (busy_o !== 1'b1 || err_o !== 1'b1 || stall_cnt_o !== exp_stall) begin
      tests_failed++;
      $display("FAIL arst_pre got busy=%b err=%b stall=%0d want 1/1/%0d", busy_o, err_o, stall_cnt_o, exp_stall);
    end
    #2;
    resetn = 1'b0;
    #1;
    tests_run++;
    if (busy_o !== 1'b0 || err_o !== 1'b0 || stall_cnt_o !== 32'd0) begin
      tests_failed++;
      $display("FAIL arst_immediate got busy=%b err=%b stall=%0d want 0/0/0", busy_o, err_o, stall_cnt_o);
    end
    issue_valid = 1'b1;
    #1;
    tests_run++;
    if (issue_ready !== 1'b0) begin
      tests_failed++; $display("FAIL arst_ready got %b want 0", issue_ready);
    end
    tick();
    idle();
    resetn = 1'b1;
    exp_stall = 32'd0;
    issue_valid = 1'b1; issue_rs = 5'd2; issue_rs_r = 1'b1;
    #1;
    tests_run++;
    if (issue_ready !== 1'b1 || busy_o !== 1'b0) begin
      tests_failed++; $display("FAIL arst_discard got ready=%b busy=%b want 1/0", issue_ready, busy_o);
    end
    idle();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_stall    = 32'd0;
    test_reset();
    test_forward();
    test_youngest();
    test_saturate();
    test_same_cycle();
    test_error_flush();
    test_branch();
    test_async_reset();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
